// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the iterative multiplier.
// Imported by seq_mul.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam logic RCA_CTRL_ADD = 1'b0;
  localparam logic RCA_CTRL_SUB = 1'b1;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/seq_mul_rca_add.sv
// Ripple-carry adder/subtractor, ctrl=0 adds, ctrl=1 subtracts.
// Pure combinational; carry-out is the WIDTH+1th sum bit.
module rca_add #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Bit-serial carry chain; subtraction uses ~b + 1.
  always_comb begin
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] bx;
    bx   = b ^ {WIDTH{ctrl}};
    c    = '0;
    sum  = '0;
    c[0] = ctrl;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    cout = c[WIDTH];
  end

endmodule

// File: rtl/seq_mul.sv
// Iterative unsigned shift-and-add multiplier.
// One adder, WIDTH cycles per product, valid/ready on both sides.
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WIDTH-1:0]    product,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = prod_w(WIDTH);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum;
  logic             cout;

  assign add_b = lo_q[0] ? mcand_q : '0;

  rca_add #(
    .WIDTH (WIDTH)
  ) u_add (
    .a    (hi_q),
    .b    (add_b),
    .ctrl (RCA_CTRL_ADD),
    .sum  (sum),
    .cout (cout)
  );

  // Next-state and datapath update for the shift-add loop.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          hi_d    = '0;
          lo_d    = b;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        {hi_d, lo_d} = {cout, sum, lo_q[WIDTH-1:1]};
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = out_valid ? PW'({hi_q, lo_q}) : '0;

endmodule
